// File: rtl/rv32i_inst_encoder_if.sv
// Field-set input and IMEM write port of the RV32I instruction encoder.
// master = field source / memory side, slave = encoder.
interface rv32i_inst_encoder_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [6:0]        in_opcode;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              mem_req;
  logic              mem_gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_fmt, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
    output mem_gnt,
    input  in_ready, mem_req, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
    input  mem_gnt,
    output in_ready, mem_req, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rv32i_inst_encoder.sv
// Encodes RV32I field sets into instruction words, buffers them in a FIFO and
// writes them to IMEM at auto-incrementing word addresses.
module rv32i_inst_encoder #(
  parameter int unsigned       ADDR_W     = 10,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  rv32i_inst_encoder_if.slave  bus,
  output logic [ADDR_W:0]      words_written,
  output logic                 idle,
  output logic                 err
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [2:0] FmtR = 3'd0;
  localparam logic [2:0] FmtI = 3'd1;
  localparam logic [2:0] FmtS = 3'd2;
  localparam logic [2:0] FmtB = 3'd3;
  localparam logic [2:0] FmtU = 3'd4;
  localparam logic [2:0] FmtJ = 3'd5;

  logic [31:0]       fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   ww_q;
  logic              err_q;
  logic              live_q;

  logic        full, empty, accept, push, pop, fmt_bad, align_bad, is_shift;
  logic [31:0] enc;

  assign full      = (cnt_q == CntW'(FIFO_DEPTH));
  assign empty     = (cnt_q == '0);
  // live_q keeps in_ready low until the first edge after reset release.
  assign bus.in_ready = live_q & ~full;
  assign accept    = bus.in_valid & bus.in_ready;
  assign fmt_bad   = bus.in_fmt[2] & bus.in_fmt[1];
  assign align_bad = ((bus.in_fmt == FmtB) || (bus.in_fmt == FmtJ)) & bus.in_imm[0];
  assign push      = accept & ~fmt_bad;
  assign pop       = ~empty & bus.mem_gnt;
  assign is_shift  = (bus.in_opcode == 7'b0010011) &&
                     ((bus.in_funct3 == 3'b001) || (bus.in_funct3 == 3'b101));

  always_comb begin
    enc = '0;
    case (bus.in_fmt)
      FmtR: enc = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd,
                   bus.in_opcode};
      FmtI: begin
        if (is_shift) begin
          enc = {bus.in_funct7, bus.in_imm[4:0], bus.in_rs1, bus.in_funct3, bus.in_rd,
                 bus.in_opcode};
        end else begin
          enc = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
        end
      end
      FmtS: enc = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_imm[4:0],
                   bus.in_opcode};
      FmtB: enc = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                   bus.in_imm[4:1], bus.in_imm[11], bus.in_opcode};
      FmtU: enc = {bus.in_imm[31:12], bus.in_rd, bus.in_opcode};
      FmtJ: enc = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11], bus.in_imm[19:12],
                   bus.in_rd, bus.in_opcode};
      default: enc = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      addr_q   <= BASE_ADDR;
      ww_q     <= '0;
      err_q    <= 1'b0;
      live_q   <= 1'b0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      addr_q   <= BASE_ADDR;
      ww_q     <= '0;
      err_q    <= 1'b0;
      live_q   <= 1'b1;
    end else begin
      live_q <= 1'b1;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
        addr_q   <= addr_q + ADDR_W'(1);
        ww_q     <= ww_q + (ADDR_W + 1)'(1);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (accept && (fmt_bad || align_bad)) begin
        err_q <= 1'b1;
      end
    end
  end

  // Storage needs no reset: contents are only visible through a non-empty head.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      fifo_q[wr_ptr_q] <= enc;
    end
  end

  assign bus.mem_req   = ~empty;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = empty ? 32'h0 : fifo_q[rd_ptr_q];
  assign words_written = ww_q;
  assign idle          = empty;
  assign err           = err_q;
endmodule

// File: tb/tb_rv32i_inst_encoder.sv
// Directed bench for rv32i_inst_encoder with a scoreboard of expected IMEM writes.
module tb_rv32i_inst_encoder;
  localparam int unsigned AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic [AW:0]   words_written;
  logic          idle;
  logic          err;

  rv32i_inst_encoder_if #(.ADDR_W(AW)) bus ();

  rv32i_inst_encoder #(
    .ADDR_W     (AW),
    .FIFO_DEPTH (4),
    .BASE_ADDR  (2'd0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (clear),
    .bus           (bus),
    .words_written (words_written),
    .idle          (idle),
    .err           (err)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          passed = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_word = '0;
  logic [AW-1:0] m_addr = '0;
  logic [AW:0]   m_ww = '0;
  logic          accepted = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  // Sample at negedge: verify/pop the head on a write, record accepted field sets.
  task automatic tick();
    @(negedge clk);
    accepted = 1'b0;
    if (rst_n && clear) begin
      exp_q.delete();
      m_addr = '0;
      m_ww   = '0;
    end else if (rst_n) begin
      if (bus.mem_req) begin
        if (exp_q.size() == 0) begin
          check("unexpected_req", 32'(bus.mem_req), 32'd0);
        end else begin
          check("wdata", bus.mem_wdata, exp_q[0]);
          check("addr", 32'(bus.mem_addr), 32'(m_addr));
          if (bus.mem_gnt) begin
            void'(exp_q.pop_front());
            m_addr++;
            m_ww++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        accepted = 1'b1;
        if (bus.in_fmt < 3'd6) exp_q.push_back(exp_word);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm, input logic [31:0] exp);
    bus.in_fmt    = fmt;
    bus.in_opcode = op;
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_imm    = imm;
    exp_word      = exp;
    bus.in_valid  = 1'b1;
  endtask

  task automatic wait_accept(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      done = accepted;
    end
    check({tag, "_accept"}, 32'(done), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input string tag, input logic [2:0] fmt, input logic [6:0] op,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                      input logic [31:0] exp);
    drive(fmt, op, f3, f7, rd, rs1, rs2, imm, exp);
    wait_accept(tag);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && (exp_q.size() != 0 || bus.mem_req); i++) tick();
    check({tag, "_drained"}, 32'(idle), 32'd1);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_fmt = '0; bus.in_opcode = '0; bus.in_funct3 = '0; bus.in_funct7 = '0;
    bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0;
    bus.mem_gnt = 1'b0;

    #2;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_err", 32'(err), 32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    check("rst_ww", 32'(words_written), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    check("ready_before_edge", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("ready_after_edge", 32'(bus.in_ready), 32'd1);

    bus.mem_gnt = 1'b1;
    send("addi", 3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093);
    send("sw", 3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_A423);
    drain("basic");
    check("ww_two", 32'(words_written), 32'd2);

    send("beq", 3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3);
    send("jal", 3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 32'h0010_00EF);
    send("lui", 3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7);
    send("srai", 3'd1, 7'h13, 3'd5, 7'h20, 5'd3, 5'd3, 5'd0, 32'h0000_0FE4, 32'h4041_D193);
    send("add", 3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0, 32'h0020_81B3);
    drain("bju");
    check("err_clean", 32'(err), 32'd0);
    check("ww_seven", 32'(words_written), 32'd7);
    check("addr_wrapped", 32'(bus.mem_addr), 32'd3);

    // Backpressure: four fill the FIFO, the fifth stalls until grants resume.
    bus.mem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send("bp_fill", 3'd1, 7'h13, 3'd0, 7'h00, 5'(i + 1), 5'd0, 5'd0, 32'(i + 16),
           {12'(i + 16), 5'd0, 3'd0, 5'(i + 1), 7'h13});
    end
    drive(3'd1, 7'h13, 3'd0, 7'h00, 5'd7, 5'd0, 5'd0, 32'd100, 32'h0640_0393);
    for (int i = 0; i < 3; i++) tick();
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    check("full_not_idle", 32'(idle), 32'd0);
    bus.mem_gnt = 1'b1;
    wait_accept("bp_fifth");
    drain("bp");
    check("ww_wrap", 32'(words_written), 32'd4);
    check("addr_after_bp", 32'(bus.mem_addr), 32'd0);

    send("bad_fmt", 3'd7, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1, 32'h0);
    for (int i = 0; i < 3; i++) tick();
    check("bad_fmt_err", 32'(err), 32'd1);
    check("bad_fmt_idle", 32'(idle), 32'd1);
    check("bad_fmt_ww", 32'(words_written), 32'd4);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_err", 32'(err), 32'd0);
    check("clr_addr", 32'(bus.mem_addr), 32'd0);
    check("clr_idle", 32'(idle), 32'd1);
    check("clr_ww", 32'(words_written), 32'd0);
    check("clr_ready", 32'(bus.in_ready), 32'd1);

    send("beq_odd", 3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd3, 32'h0000_0163);
    drain("odd");
    check("odd_err", 32'(err), 32'd1);
    check("odd_ww", 32'(words_written), 32'd1);

    // Reset while two words are queued drops them without any write.
    bus.mem_gnt = 1'b0;
    send("q0", 3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1, 32'h0010_0093);
    send("q1", 3'd1, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'd2, 32'h0020_0113);
    check("queued_req", 32'(bus.mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_req", 32'(bus.mem_req), 32'd0);
    check("midrst_idle", 32'(idle), 32'd1);
    check("midrst_ready", 32'(bus.in_ready), 32'd0);
    check("midrst_addr", 32'(bus.mem_addr), 32'd0);
    check("midrst_ww", 32'(words_written), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    exp_q.delete();
    m_addr = '0;
    m_ww   = '0;
    bus.mem_gnt = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("post_rst_idle", 32'(idle), 32'd1);
    check("post_rst_ww", 32'(words_written), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/rv32i_inst_encoder.md
# rv32i_inst_encoder

Encodes decoded RV32I instruction fields (format, opcode, funct3/funct7, register indices, immediate) into 32-bit instruction words and writes them sequentially into instruction memory. It is the inverse of the core's instruction decode path, used by the program loader and by self-test sequencers to build programs in IMEM without an external assembler. Encoded words pass through a small FIFO and drain to memory over a request/grant write port with an auto-incrementing word address.

## Interface
- ADDR_W, 10, IMEM word-address width
- FIFO_DEPTH, 4, encoded-word buffer depth (power of 2, ≥2)
- BASE_ADDR, 0, word address loaded on reset and on clear
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous flush: empties FIFO, reloads address, zeroes count, clears err
- in_valid  in  1  field set valid
- in_ready  out  1  encoder can accept a field set
- in_fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 invalid
- in_opcode  in  7  opcode, copied to inst[6:0]
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (R format, I-format shifts)
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  32  immediate as a byte-offset value (U: upper 20 bits significant)
- mem_req  out  1  write request
- mem_gnt  in  1  memory accepts current word
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded instruction
- words_written  out  ADDR_W+1  words accepted by memory since reset/clear, wraps
- idle  out  1  FIFO empty and no request pending
- err  out  1  sticky error flag

## Operation
- Encoding (bit fields MSB→LSB):
  - R: funct7 | rs2 | rs1 | funct3 | rd | opcode
  - I: imm[11:0] | rs1 | funct3 | rd | opcode; when opcode=0010011 and funct3 ∈ {001,101}: imm[11:5] replaced by funct7, imm[4:0] kept
  - S: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | opcode
  - B: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | opcode
  - U: imm[31:12] | rd | opcode
  - J: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | opcode
- Unused fields ignored; no range checking of imm beyond listed bits.
- Accept on in_valid & in_ready; in_ready = FIFO not full. Accepted word pushed into FIFO same edge.
- in_fmt 6/7: handshake completes, nothing pushed, err set.
- B or J with in_imm[0]=1: word encoded and pushed (bit 0 dropped), err set.
- Drain: mem_req = FIFO not empty; mem_wdata = FIFO head, mem_addr = address counter. On mem_req & mem_gnt: pop, address +1 (wraps modulo 2^ADDR_W), words_written +1 (wraps modulo 2^(ADDR_W+1)).
- mem_addr and mem_wdata stable while mem_req high and mem_gnt low.
- Push and pop on same edge allowed when not full; count unchanged.
- clear has priority over push, pop and err set on the same edge; in_ready stays combinational on FIFO level (high after clear).

## Timing
- Reset (async, rst_n low): FIFO empty, mem_req=0, mem_addr=BASE_ADDR, mem_wdata=0, words_written=0, err=0, idle=1, in_ready=0 while rst_n low, 1 from first edge after release.
- Latency: field accepted at edge N → mem_req high, word on mem_wdata after edge N (cycle N+1). No input-to-output combinational path.
- Throughput: one word/cycle with mem_gnt held high.
- Full: in_ready low when FIFO_DEPTH entries held; a pop that cycle raises in_ready the following cycle (no same-cycle bypass).
- idle = ~mem_req.
- Reset asserted mid-transfer drops pending words; no memory write completes after rst_n falls.

## Test plan
- Single fields, mem_gnt=1: addi x1,x0,5 → 0x00500093 at addr 0; sw x2,8(x1) → 0x0020A423 at addr 1; words_written=2.
- B/J/U: beq x0,x0,imm=-4 → 0xFE000EE3; jal x1,imm=0x800 → 0x001000EF; lui x5,imm=0x12345000 → 0x123452B7; err stays 0.
- Shift: srai x3,x3,4 (opcode 0x13, funct3 5, funct7 0x20) → 0x4041D193.
- Backpressure: mem_gnt=0, push 5 back-to-back → 4 accepted, in_ready low at 5th; mem_wdata/mem_addr constant; raise mem_gnt → 4 writes in order at consecutive addresses, then 5th accepted.
- Errors: in_fmt=7 → no write, err=1; B with imm=3 → word written, err=1; clear → err=0, mem_addr=BASE_ADDR, FIFO empty, words_written=0.
- Wrap/reset: ADDR_W=2, 5 writes → addresses 0,1,2,3,0; drop rst_n with 2 words queued → mem_req=0 immediately, idle=1.
